// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (IFU, LSU), one-port memory arbiter and sequencer.
// Accepts one transaction at a time, round-robin on ties, drives the memory
// request/response handshake, routes the response back to the owning master
// and aborts a stalled transaction with an error after TIMEOUT cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   ifu_req_valid/ready      fetch request handshake, ifu_addr payload
//   ifu_resp_valid/rdata/err fetch response (one-cycle pulse, err = timeout)
//   lsu_req_valid/ready      load/store request handshake
//   lsu_addr/wen/wdata/wmask load/store payload
//   lsu_resp_valid/rdata/err load/store response (one-cycle pulse)
//   mem_req_valid/ready      memory request handshake
//   mem_addr/wen/wdata/wmask latched request payload
//   mem_resp_valid, mem_rdata memory response
//   busy                     a transaction is in flight
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;  // 1 = LSU owns the transaction
    logic                last_q, last_d;    // 1 = LSU was granted last
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                ifu_rv_q, lsu_rv_q;
    logic                ifu_err_q, lsu_err_q;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

    logic grant_ifu, grant_lsu, expire, done, done_err;
    logic [DATA_W-1:0] resp_data;

    // On a tie the master that was not granted last wins.
    assign grant_ifu = ifu_req_valid & (~lsu_req_valid | last_q);
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
    assign expire    = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        done          = 1'b0;
        done_err      = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (grant_ifu) begin
                    ifu_req_ready = 1'b1;
                    owner_d       = 1'b0;
                    last_d        = 1'b0;
                    addr_d        = ifu_addr;
                    wen_d         = 1'b0;
                    wdata_d       = '0;
                    wmask_d       = '1;
                    state_d       = StReq;
                end else if (grant_lsu) begin
                    lsu_req_ready = 1'b1;
                    owner_d       = 1'b1;
                    last_d        = 1'b1;
                    addr_d        = lsu_addr;
                    wen_d         = lsu_wen;
                    wdata_d       = lsu_wdata;
                    wmask_d       = lsu_wmask;
                    state_d       = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (expire) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = StIdle;
                end else if (mem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the expiry cycle still counts as a success.
                if (mem_resp_valid) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (expire) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_data   = done_err ? '0 : mem_rdata;
    assign ifu_rdata_d = (done & ~owner_q) ? resp_data : ifu_rdata_q;
    assign lsu_rdata_d = (done & owner_q) ? resp_data : lsu_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rv_q    <= done & ~owner_q;
            lsu_rv_q    <= done & owner_q;
            ifu_err_q   <= done & ~owner_q & done_err;
            lsu_err_q   <= done & owner_q & done_err;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign mem_req_valid  = (state_q == StReq);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign busy           = (state_q != StIdle);
    assign ifu_resp_valid = ifu_rv_q;
    assign ifu_resp_err   = ifu_err_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign lsu_resp_err   = lsu_err_q;
    assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic for mem_arbiter,
// checked every cycle against a transaction-level model (grant time, handshake
// flag and elapsed-cycle arithmetic for the timeout).
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0] lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0] mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_busy, m_owner, m_last, m_acc, m_ifu_v, m_lsu_v, m_err;
    int            m_g;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ifu_rd, m_lsu_rd;
    logic [MW-1:0] m_wmask;
    bit            m_wen;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_acc = 0; m_g = 0;
        m_ifu_v = 0; m_lsu_v = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = 0;
        m_ifu_rd = '0; m_lsu_rd = '0;
    endtask

    task automatic model_finish(input bit e, input logic [DW-1:0] d);
        if (m_owner) begin m_lsu_v = 1; m_lsu_rd = d; end
        else begin m_ifu_v = 1; m_ifu_rd = d; end
        m_err  = e;
        m_busy = 0;
    endtask

    // Compare outputs mid-cycle (inputs settled), then advance the model
    // across the coming rising edge.
    initial begin
        bit wi, wl;
        int el;
        model_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!rst) model_reset();
            wi = ifu_req_valid && (!lsu_req_valid || m_last);
            wl = lsu_req_valid && (!ifu_req_valid || !m_last);
            chk("ifu_req_ready", 64'(ifu_req_ready), 64'(rst && !m_busy && wi));
            chk("lsu_req_ready", 64'(lsu_req_ready), 64'(rst && !m_busy && wl));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(m_busy && !m_acc));
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_wen", 64'(mem_wen), 64'(m_wen));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
            chk("ifu_resp_valid", 64'(ifu_resp_valid), 64'(m_ifu_v));
            chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(m_lsu_v));
            chk("ifu_rdata", 64'(ifu_rdata), 64'(m_ifu_rd));
            chk("lsu_rdata", 64'(lsu_rdata), 64'(m_lsu_rd));
            if (m_ifu_v) chk("ifu_resp_err", 64'(ifu_resp_err), 64'(m_err));
            if (m_lsu_v) chk("lsu_resp_err", 64'(lsu_resp_err), 64'(m_err));
            if (rst) begin
                m_ifu_v = 0;
                m_lsu_v = 0;
                if (!m_busy) begin
                    if (wi || wl) begin
                        m_busy = 1; m_owner = wl; m_last = wl; m_g = cyc; m_acc = 0;
                        if (wl) begin
                            m_addr = lsu_addr; m_wen = lsu_wen;
                            m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                        end else begin
                            m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wmask = '1;
                        end
                    end
                end else begin
                    el = cyc - m_g;  // cycles since grant
                    if (m_acc && mem_resp_valid) model_finish(0, mem_rdata);
                    else if (el == TO) model_finish(1, '0);
                    else if (!m_acc && mem_req_ready) m_acc = 1;
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        bit grants[$];
        bit prev_lsu;
        idle_inputs();
        repeat (3) tick();
        rst = 1;

        // T1: single fetch, minimum latency.
        tick(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; #3;
        chk("t1 ifu_req_ready c0", 64'(ifu_req_ready), 64'd1);
        chk("t1 lsu_req_ready c0", 64'(lsu_req_ready), 64'd0);
        tick(); mem_req_ready = 1; #3;
        chk("t1 mem_req_valid c1", 64'(mem_req_valid), 64'd1);
        chk("t1 mem_addr c1", 64'(mem_addr), 64'h8000_0000);
        chk("t1 mem_wmask c1", 64'(mem_wmask), 64'hF);
        tick(); mem_resp_valid = 1; mem_rdata = 32'h0000_0413; #3;
        chk("t1 busy c2", 64'(busy), 64'd1);
        tick(); #3;
        chk("t1 ifu_resp_valid c3", 64'(ifu_resp_valid), 64'd1);
        chk("t1 ifu_rdata c3", 64'(ifu_rdata), 64'h413);
        chk("t1 ifu_resp_err c3", 64'(ifu_resp_err), 64'd0);
        chk("t1 lsu_resp_valid c3", 64'(lsu_resp_valid), 64'd0);
        chk("t1 busy c3", 64'(busy), 64'd0);
        tick(); #3;
        chk("t1 ifu_resp_valid c4", 64'(ifu_resp_valid), 64'd0);

        // T2: both masters valid continuously after reset -> alternate grants.
        tick(); rst = 0;
        tick(); rst = 1;
        prev_lsu = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
            lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
            lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
            mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h1111_0000 + i;
            #3;
            if (prev_lsu) begin
                chk("t2 store mem_addr", 64'(mem_addr), 64'h8000_1000);
                chk("t2 store mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
                chk("t2 store mem_wen", 64'(mem_wen), 64'd1);
                chk("t2 store mem_wmask", 64'(mem_wmask), 64'hF);
            end
            if (ifu_req_ready || lsu_req_ready) grants.push_back(lsu_req_ready);
            prev_lsu = lsu_req_ready;
        end
        chk("t2 grant count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("t2 grant order", 64'(grants[i]), 64'(i % 2));
        tick(); tick();

        // T3: slow memory; payload stable, one pulse, busy until the pulse.
        tick(); ifu_req_valid = 1; ifu_addr = 32'h0000_1234; #3;
        chk("t3 ifu_req_ready", 64'(ifu_req_ready), 64'd1);
        for (int i = 1; i <= 5; i++) begin
            tick(); mem_resp_valid = 1; mem_rdata = 32'hBAD; #3;
            chk("t3 mem_req_valid held", 64'(mem_req_valid), 64'd1);
            chk("t3 mem_addr held", 64'(mem_addr), 64'h1234);
        end
        tick(); mem_req_ready = 1; #3;
        chk("t3 mem_req_valid c6", 64'(mem_req_valid), 64'd1);
        for (int i = 7; i <= 13; i++) begin
            tick(); #3;
            chk("t3 busy waiting", 64'(busy), 64'd1);
            chk("t3 no early pulse", 64'(ifu_resp_valid), 64'd0);
        end
        tick(); mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001; #3;
        tick(); #3;
        chk("t3 ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        chk("t3 ifu_rdata", 64'(ifu_rdata), 64'hCAFE_0001);
        chk("t3 busy at pulse", 64'(busy), 64'd0);
        tick(); #3;
        chk("t3 single pulse", 64'(ifu_resp_valid), 64'd0);

        // T4: memory never responds -> error pulse TO+1 cycles after grant.
        tick(); lsu_req_valid = 1; lsu_addr = 32'h0000_2000; #3;
        chk("t4 lsu_req_ready", 64'(lsu_req_ready), 64'd1);
        for (int k = 1; k <= TO; k++) begin
            tick(); mem_req_ready = 1; #3;
            chk("t4 no pulse before expiry", 64'(lsu_resp_valid), 64'd0);
        end
        tick(); #3;
        chk("t4 lsu_resp_valid", 64'(lsu_resp_valid), 64'd1);
        chk("t4 lsu_resp_err", 64'(lsu_resp_err), 64'd1);
        chk("t4 lsu_rdata", 64'(lsu_rdata), 64'd0);
        chk("t4 ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
        tick(); tick();
        tick(); mem_resp_valid = 1; mem_rdata = 32'h5555_5555;
        tick(); #3;
        chk("t4 late resp ignored", 64'(lsu_resp_valid), 64'd0);
        chk("t4 busy idle", 64'(busy), 64'd0);

        // T5: response lands in the expiry cycle -> success.
        tick(); ifu_req_valid = 1; ifu_addr = 32'h0000_3000;
        tick(); mem_req_ready = 1;
        for (int k = 2; k < TO; k++) tick();
        tick(); mem_resp_valid = 1; mem_rdata = 32'h0BAD_F00D;
        tick(); #3;
        chk("t5 ifu_resp_valid", 64'(ifu_resp_valid), 64'd1);
        chk("t5 ifu_resp_err", 64'(ifu_resp_err), 64'd0);
        chk("t5 ifu_rdata", 64'(ifu_rdata), 64'h0BAD_F00D);

        // T6: reset during RESP.
        tick(); ifu_req_valid = 1; ifu_addr = 32'h0000_4000;
        tick(); mem_req_ready = 1;
        tick(); #3;
        chk("t6 busy in resp", 64'(busy), 64'd1);
        tick(); rst = 0; mem_resp_valid = 1; mem_rdata = 32'h7777; #1;
        chk("t6 busy reset", 64'(busy), 64'd0);
        chk("t6 mem_addr reset", 64'(mem_addr), 64'd0);
        chk("t6 ifu_rdata reset", 64'(ifu_rdata), 64'd0);
        tick(); mem_resp_valid = 1;
        tick(); rst = 1; mem_resp_valid = 1;
        tick(); #3;
        chk("t6 no pulse after reset", 64'(ifu_resp_valid), 64'd0);
        tick(); ifu_req_valid = 1; lsu_req_valid = 1; #3;
        chk("t6 tie to ifu", 64'(ifu_req_ready), 64'd1);
        chk("t6 tie not lsu", 64'(lsu_req_ready), 64'd0);
        tick(); mem_req_ready = 1;
        tick(); mem_resp_valid = 1;
        tick();

        // Randomized traffic; second half uses a sluggish memory to hit timeouts.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 399) != 0);
            if (rst) begin
                ifu_req_valid = 1'($urandom_range(0, 1));
                lsu_req_valid = 1'($urandom_range(0, 1));
            end
            ifu_addr       = $urandom;
            lsu_addr       = $urandom;
            lsu_wen        = 1'($urandom_range(0, 1));
            lsu_wdata      = $urandom;
            lsu_wmask      = 4'($urandom_range(0, 15));
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = (i < 1500) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 19) == 0);
            mem_rdata      = $urandom;
        end
        tick(); rst = 1;
        repeat (TO + 4) tick();
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
